// File: rtl/txt_pkg.sv
// Shared constants and FSM state encodings for the text cursor writer.
// Optional feature macro: TXT_CLEAR_SCREEN_EN (adds the form-feed screen clear state).
package txt_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

`ifdef TXT_CLEAR_SCREEN_EN
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_LINE   = 2'd1,
        ST_CLR_SCREEN = 2'd2
    } txt_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_LINE = 2'd1
    } txt_state_e;
`endif

endpackage

// File: rtl/txt_cursor_ctr.sv
// Cursor position register: home, newline, printable advance with line wrap,
// backspace, and row wrap at the bottom of the buffer.
module txt_cursor_ctr #(
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    parameter int HOME_COL = 0,
    parameter int HOME_ROW = 0,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             home,
    input  logic             newline,
    input  logic             print_adv,
    input  logic             back,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    logic [ROW_W-1:0] next_row;

    // Row that follows the current one, wrapping from the bottom row back to the top.
    always_comb begin
        next_row = (row == ROW_LAST) ? '0 : row + ROW_ONE;
    end

    // Cursor update; home has priority so a soft home always lands on the home cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= COL_W'(HOME_COL);
            row <= ROW_W'(HOME_ROW);
        end else if (home) begin
            col <= COL_W'(HOME_COL);
            row <= ROW_W'(HOME_ROW);
        end else if (newline) begin
            col <= '0;
            row <= next_row;
        end else if (print_adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= next_row;
            end else begin
                col <= col + COL_ONE;
            end
        end else if (back) begin
            if (col != '0) begin
                col <= col - COL_ONE;
            end
        end
    end

endmodule

// File: rtl/text_cursor_writer.sv
// Terminal-style cursor engine: consumes received bytes over valid/ready and
// drives a registered text-RAM write port (printable chars, CR/LF/BS, line and
// row wrap, clearing of each newly entered row).
// Optional feature macro: TXT_CLEAR_SCREEN_EN (form feed clears the whole buffer).
module text_cursor_writer
    import txt_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    parameter int HOME_COL = 0,
    parameter int HOME_ROW = 0,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             soft_home,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             busy
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
`ifdef TXT_CLEAR_SCREEN_EN
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
`endif

    txt_state_e       state;
    logic [COL_W-1:0] clr_col;
    logic             last_cr;
    logic             accept;
    logic             is_print;
    logic             is_cr;
    logic             is_lf;
    logic             is_bs;
    logic             do_newline;
    logic             do_print;
    logic             do_back;
    logic             do_home;
`ifdef TXT_CLEAR_SCREEN_EN
    logic [ROW_W-1:0] clr_row;
    logic             is_ff;
    logic             screen_done;
`endif

    assign in_ready = (state == ST_IDLE) && !soft_home;
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Byte classification and cursor commands for the accepted byte.
    always_comb begin
        is_print   = (in_data >= PRINT_MIN) && (in_data <= PRINT_MAX);
        is_cr      = (in_data == CHAR_CR);
        is_lf      = (in_data == CHAR_LF);
        is_bs      = (in_data == CHAR_BS);
        // An LF directly after a CR is the second half of a CRLF pair, not a new line.
        do_newline = accept && (is_cr || (is_lf && !last_cr));
        do_print   = accept && is_print;
        do_back    = accept && is_bs;
`ifdef TXT_CLEAR_SCREEN_EN
        is_ff       = (in_data == CHAR_FF);
        screen_done = (state == ST_CLR_SCREEN) && (clr_col == COL_LAST) && (clr_row == ROW_LAST);
        do_home     = soft_home || screen_done;
`else
        do_home     = soft_home;
`endif
    end

    txt_cursor_ctr #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .HOME_COL (HOME_COL),
        .HOME_ROW (HOME_ROW),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_cursor (
        .clk       (clk),
        .reset_n   (reset_n),
        .home      (do_home),
        .newline   (do_newline),
        .print_adv (do_print),
        .back      (do_back),
        .col       (cur_col),
        .row       (cur_row)
    );

    // Control FSM, clear counters and the registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            clr_col <= '0;
            last_cr <= 1'b0;
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
`ifdef TXT_CLEAR_SCREEN_EN
            clr_row <= '0;
`endif
        end else if (soft_home) begin
            state   <= ST_IDLE;
            clr_col <= '0;
            last_cr <= 1'b0;
            wr_en   <= 1'b0;
`ifdef TXT_CLEAR_SCREEN_EN
            clr_row <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_en <= 1'b0;
                    if (accept) begin
                        last_cr <= is_cr;
                        if (is_print) begin
                            wr_en   <= 1'b1;
                            wr_row  <= cur_row;
                            wr_col  <= cur_col;
                            wr_data <= in_data;
                            if (cur_col == COL_LAST) begin
                                state   <= ST_CLR_LINE;
                                clr_col <= '0;
                            end
                        end else if (is_cr || (is_lf && !last_cr)) begin
                            state   <= ST_CLR_LINE;
                            clr_col <= '0;
                        end else if (is_bs && (cur_col != '0)) begin
                            wr_en   <= 1'b1;
                            wr_row  <= cur_row;
                            wr_col  <= cur_col - COL_ONE;
                            wr_data <= CHAR_SPACE;
`ifdef TXT_CLEAR_SCREEN_EN
                        end else if (is_ff) begin
                            state   <= ST_CLR_SCREEN;
                            clr_col <= '0;
                            clr_row <= '0;
`endif
                        end
                    end
                end
                // The cursor already points at the freshly entered row.
                ST_CLR_LINE: begin
                    wr_en   <= 1'b1;
                    wr_row  <= cur_row;
                    wr_col  <= clr_col;
                    wr_data <= CHAR_SPACE;
                    if (clr_col == COL_LAST) begin
                        state   <= ST_IDLE;
                        clr_col <= '0;
                    end else begin
                        clr_col <= clr_col + COL_ONE;
                    end
                end
`ifdef TXT_CLEAR_SCREEN_EN
                ST_CLR_SCREEN: begin
                    wr_en   <= 1'b1;
                    wr_row  <= clr_row;
                    wr_col  <= clr_col;
                    wr_data <= CHAR_SPACE;
                    if (clr_col == COL_LAST) begin
                        clr_col <= '0;
                        if (clr_row == ROW_LAST) begin
                            state   <= ST_IDLE;
                            clr_row <= '0;
                        end else begin
                            clr_row <= clr_row + ROW_ONE;
                        end
                    end else begin
                        clr_col <= clr_col + COL_ONE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Self-checking bench for text_cursor_writer (COLS=32, ROWS=4, home (0,0)).
module tb_text_cursor_writer;

    localparam int COLS  = 32;
    localparam int ROWS  = 4;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             soft_home;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // write log entries are row*65536 + col*256 + data
    int         wlog[$];
    logic [7:0] ram [ROWS][COLS];

    // reference model state
    logic [7:0] m_scr [ROWS][COLS];
    int         m_col, m_row;
    bit         m_lcr;

    text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .HOME_COL(0), .HOME_ROW(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_home (soft_home),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // mirror of the text RAM plus a log of every write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            ram[wr_row][wr_col] = wr_data;
            wlog.push_back(int'(wr_row) * 65536 + int'(wr_col) * 256 + int'(wr_data));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ent(input int r, input int c, input int d);
        return r * 65536 + c * 256 + d;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_home();
        @(negedge clk);
        soft_home = 1'b1;
        @(posedge clk);
        #1;
        soft_home = 1'b0;
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int c = 0; c < COLS; c++) m_scr[m_row][c] = 8'h20;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) begin
            model_newline();
            m_lcr = 1'b1;
        end else begin
            if (b == 8'h0A && !m_lcr) model_newline();
            else if (b >= 8'h20 && b <= 8'h7E) begin
                m_scr[m_row][m_col] = b;
                if (m_col == COLS - 1) model_newline();
                else m_col++;
            end else if (b == 8'h08 && m_col > 0) begin
                m_col--;
                m_scr[m_row][m_col] = 8'h20;
            end
`ifdef TXT_CLEAR_SCREEN_EN
            else if (b == 8'h0C) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) m_scr[r][c] = 8'h20;
                m_col = 0;
                m_row = 0;
            end
`endif
            m_lcr = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cur_col !== 0 || cur_row !== 0) begin
            errors++;
            $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cur_col, cur_row);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_row !== 0 || wr_col !== 0 || wr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_wr: got en=%b row=%0d col=%0d data=%h required 0", wr_en, wr_row, wr_col, wr_data);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: got busy=%b ready=%b required 0/1", busy, in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_print_ab();
        wlog.delete();
        send("A");
        send("B");
        wait_idle();
        checks++;
        if (wlog.size() != 2 || wlog[0] != ent(0, 0, 8'h41) || wlog[1] != ent(0, 1, 8'h42)) begin
            errors++;
            $display("FAIL print_ab_writes: got %0d writes first=%h required 2 writes (0,0)A (0,1)B", wlog.size(), (wlog.size() > 0) ? wlog[0] : 0);
        end
        checks++;
        if (cur_col !== 2 || cur_row !== 0) begin
            errors++;
            $display("FAIL print_ab_cursor: got (%0d,%0d) required (2,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_line_wrap();
        int low = 0;
        int bad = -1;
        pulse_home();
        wlog.delete();
        for (int i = 0; i < COLS - 1; i++) send("x");
        send("x");
        @(negedge clk);
        while (in_ready === 1'b0 && low < 100) begin
            low++;
            @(negedge clk);
        end
        wait_idle();
        checks++;
        if (low != COLS) begin
            errors++;
            $display("FAIL wrap_ready_low: got %0d cycles required %0d", low, COLS);
        end
        for (int i = 0; i < 2 * COLS && bad < 0; i++) begin
            int exp = (i < COLS) ? ent(0, i, 8'h78) : ent(1, i - COLS, 8'h20);
            if (i >= wlog.size() || wlog[i] != exp) bad = i;
        end
        checks++;
        if (bad >= 0 || wlog.size() != 2 * COLS) begin
            errors++;
            $display("FAIL wrap_writes: got %0d writes, first bad index %0d, required %0d writes", wlog.size(), bad, 2 * COLS);
        end
        checks++;
        if (cur_col !== 0 || cur_row !== 1) begin
            errors++;
            $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", cur_col, cur_row);
        end
    endtask

    task automatic test_crlf_row_wrap();
        int bad = -1;
        pulse_home();
        for (int i = 0; i < 3; i++) send(8'h0A);
        wait_idle();
        checks++;
        if (cur_row !== 3) begin
            errors++;
            $display("FAIL lf_rows: got row %0d required 3", cur_row);
        end
        wlog.delete();
        send(8'h0D);
        send(8'h0A);
        wait_idle();
        for (int i = 0; i < COLS && bad < 0; i++)
            if (i >= wlog.size() || wlog[i] != ent(0, i, 8'h20)) bad = i;
        checks++;
        if (bad >= 0 || wlog.size() != COLS) begin
            errors++;
            $display("FAIL crlf_writes: got %0d writes, first bad %0d, required %0d spaces on row 0", wlog.size(), bad, COLS);
        end
        checks++;
        if (cur_col !== 0 || cur_row !== 0) begin
            errors++;
            $display("FAIL crlf_cursor: got (%0d,%0d) required (0,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_backspace();
        pulse_home();
        wlog.delete();
        send(8'h08);
        wait_idle();
        checks++;
        if (wlog.size() != 0 || cur_col !== 0) begin
            errors++;
            $display("FAIL bs_col0: got %0d writes col %0d required 0 writes col 0", wlog.size(), cur_col);
        end
        send("M");
        send("N");
        wait_idle();
        wlog.delete();
        send("Q");
        send(8'h08);
        wait_idle();
        checks++;
        if (wlog.size() != 2 || wlog[0] != ent(0, 2, 8'h51) || wlog[1] != ent(0, 2, 8'h20)) begin
            errors++;
            $display("FAIL bs_writes: got %0d writes first=%h required (0,2)Q then (0,2)20", wlog.size(), (wlog.size() > 0) ? wlog[0] : 0);
        end
        checks++;
        if (cur_col !== 2 || cur_row !== 0) begin
            errors++;
            $display("FAIL bs_cursor: got (%0d,%0d) required (2,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_soft_home();
        logic rdy;
        pulse_home();
        send("K");
        wait_idle();
        wlog.delete();
        @(negedge clk);
        soft_home = 1'b1;
        in_valid  = 1'b1;
        in_data   = "Z";
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
        soft_home = 1'b0;
        in_valid  = 1'b0;
        wait_idle();
        checks++;
        if (rdy !== 1'b0 || wlog.size() != 0 || cur_col !== 0) begin
            errors++;
            $display("FAIL home_blocks_byte: got ready=%b writes=%0d col=%0d required 0/0/0", rdy, wlog.size(), cur_col);
        end
        send(8'h0A);
        wlog.delete();
        repeat (5) @(negedge clk);
        soft_home = 1'b1;
        @(posedge clk);
        #1;
        soft_home = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL home_abort: got wr_en=%b busy=%b ready=%b required 0/0/1", wr_en, busy, in_ready);
        end
        checks++;
        if (cur_col !== 0 || cur_row !== 0 || wlog.size() != 4) begin
            errors++;
            $display("FAIL home_abort_state: got (%0d,%0d) writes=%0d required (0,0) writes=4", cur_col, cur_row, wlog.size());
        end
    endtask

    task automatic test_form_feed();
        int bad = -1;
        pulse_home();
        send("a");
        wait_idle();
        wlog.delete();
        send(8'h0C);
        wait_idle();
`ifdef TXT_CLEAR_SCREEN_EN
        for (int i = 0; i < ROWS * COLS && bad < 0; i++)
            if (i >= wlog.size() || wlog[i] != ent(i / COLS, i % COLS, 8'h20)) bad = i;
        checks++;
        if (bad >= 0 || wlog.size() != ROWS * COLS) begin
            errors++;
            $display("FAIL ff_writes: got %0d writes first bad %0d required %0d", wlog.size(), bad, ROWS * COLS);
        end
        checks++;
        if (cur_col !== 0 || cur_row !== 0) begin
            errors++;
            $display("FAIL ff_cursor: got (%0d,%0d) required (0,0)", cur_col, cur_row);
        end
`else
        checks++;
        if (wlog.size() != 0 || cur_col !== 1 || cur_row !== 0 || bad != -1) begin
            errors++;
            $display("FAIL ff_ignored: got %0d writes cursor (%0d,%0d) required 0 writes (1,0)", wlog.size(), cur_col, cur_row);
        end
`endif
    endtask

    task automatic test_reset_mid_clear();
        pulse_home();
        send(8'h0A);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || in_ready !== 1'b1 || cur_col !== 0 || cur_row !== 0) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy=%b wr_en=%b ready=%b (%0d,%0d) required 0/0/1 (0,0)", busy, wr_en, in_ready, cur_col, cur_row);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] others [7] = '{8'h00, 8'h01, 8'h1B, 8'h7F, 8'h80, 8'hFF, 8'h0C};
        logic [7:0] b;
        int r;
        int bad;
        pulse_home();
        for (int i = 0; i < ROWS; i++) send(8'h0A);
        wait_idle();
        for (int rr = 0; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++) m_scr[rr][c] = 8'h20;
        m_col = 0;
        m_row = 0;
        m_lcr = 1'b0;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_home();
                m_col = 0;
                m_row = 0;
                m_lcr = 1'b0;
            end else begin
                if (r < 70)      b = 8'($urandom_range(32, 126));
                else if (r < 78) b = 8'h0D;
                else if (r < 86) b = 8'h0A;
                else if (r < 94) b = 8'h08;
                else             b = others[$urandom_range(0, 6)];
                send(b);
                model_byte(b);
            end
            wait_idle();
            checks++;
            if (int'(cur_col) != m_col || int'(cur_row) != m_row) begin
                errors++;
                $display("FAIL rand_cursor: step %0d got (%0d,%0d) required (%0d,%0d)", it, cur_col, cur_row, m_col, m_row);
            end
            if (it % 25 == 24) begin
                bad = 0;
                for (int rr = 0; rr < ROWS; rr++)
                    for (int c = 0; c < COLS; c++)
                        if (ram[rr][c] !== m_scr[rr][c]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand_screen: step %0d got %0d differing cells required 0", it, bad);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        soft_home = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_print_ab();
        test_line_wrap();
        test_crlf_row_wrap();
        test_backspace();
        test_soft_home();
        test_form_feed();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
